// File: rtl/snn_pkg.sv
// Shared definitions for the spiking front end: encoder state type,
// LFSR constants and the LFSR helper functions.
package snn_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        READY = 2'd1,
        RUN   = 2'd2
    } enc_state_t;

    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [15:0] SEED_STRIDE = 16'h01F3;

    // One step of a 16-bit right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
        logic [15:0] shifted;
        shifted = q >> 1;
        return q[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

    // Per-input seed: base plus a fixed stride per lane; an all-zero seed
    // would lock the LFSR, so it is replaced with 1.
    function automatic logic [15:0] lfsr16_seed(input logic [15:0] base,
                                                input int unsigned lane);
        logic [15:0] s;
        s = base + (16'(lane) * SEED_STRIDE);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/spike_rate_encoder_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed reload and step enable.
// Reset also returns the register to its seed.
module lfsr16
    import snn_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] q
);

    // Seed on reset or reload, otherwise advance one step when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= seed;
        end else if (load) begin
            q <= seed;
        end else if (en) begin
            q <= lfsr16_next(q);
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: pixels are written over a valid/ready stream, then a start
// pulse produces NUM_STEPS spike vectors, each bit being an LFSR-vs-pixel
// compare. Feeds the spike_in bus of the first integrate-and-fire layer.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int          NUM_INPUTS  = 4,
    parameter int          PIXEL_WIDTH = 8,
    parameter int          NUM_STEPS   = 100,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pixel_valid,
    input  logic [PIXEL_WIDTH-1:0] pixel_data,
    output logic                   pixel_ready,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   spike_valid,
    output logic [NUM_INPUTS-1:0]  spike_out
);

    localparam int IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int STEP_W = $clog2(NUM_STEPS + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_INPUTS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

    enc_state_t             state;
    enc_state_t             state_next;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_next;
    logic [STEP_W-1:0]      step;
    logic [PIXEL_WIDTH-1:0] pixel [NUM_INPUTS];
    logic [15:0]            lfsr_q [NUM_INPUTS];

    logic                   write_acc;
    logic [IDX_W-1:0]       write_addr;
    logic                   start_acc;
    logic                   run_step;
    logic                   run_last;
    logic [NUM_INPUTS-1:0]  spike_cmp;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes.
    // A write arriving in READY takes priority over start.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        write_acc  = 1'b0;
        write_addr = idx;
        start_acc  = 1'b0;
        run_step   = 1'b0;
        run_last   = 1'b0;
        unique case (state)
            LOAD: begin
                if (pixel_valid) begin
                    write_acc  = 1'b1;
                    write_addr = idx;
                    if (idx == IDX_LAST) begin
                        idx_next   = '0;
                        state_next = READY;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            READY: begin
                if (pixel_valid) begin
                    write_acc  = 1'b1;
                    write_addr = '0;
                    if (NUM_INPUTS == 1) begin
                        idx_next = '0;
                    end else begin
                        idx_next   = IDX_W'(1);
                        state_next = LOAD;
                    end
                end else if (start) begin
                    start_acc  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                run_step = 1'b1;
                if (step == STEP_LAST) begin
                    run_last   = 1'b1;
                    state_next = READY;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Pixel register file, written one entry per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                pixel[i] <= '0;
            end
        end else if (write_acc) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (write_addr == IDX_W'(i)) begin
                    pixel[i] <= pixel_data;
                end
            end
        end
    end

    // One LFSR per lane; all reseed on an accepted start so runs repeat.
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lfsr
        localparam logic [15:0] LANE_SEED = lfsr16_seed(LFSR_SEED, g);

        lfsr16 u_lfsr (
            .clk  (clk),
            .rst  (rst),
            .load (start_acc),
            .seed (LANE_SEED),
            .en   (run_step),
            .q    (lfsr_q[g])
        );
    end

    // Spike decision: top PIXEL_WIDTH bits of the LFSR against the intensity.
    always_comb begin
        spike_cmp = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            spike_cmp[i] = (lfsr_q[i][15 -: PIXEL_WIDTH] < pixel[i]);
        end
    end

    // Load index and step counter; step restarts from zero on each start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            step <= '0;
        end else begin
            idx <= idx_next;
            if (start_acc) begin
                step <= '0;
            end else if (run_step) begin
                step <= step + STEP_W'(1);
            end
        end
    end

    // Registered outputs; status flags follow the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            spike_valid <= 1'b0;
            spike_out   <= '0;
        end else begin
            pixel_ready <= (state_next != RUN);
            busy        <= (state_next == RUN);
            done        <= run_last;
            spike_valid <= run_step;
            spike_out   <= run_step ? spike_cmp : '0;
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: scoreboard-checked runs on a 4-input,
// 100-step instance plus directed checks on a 1-input, 1-step instance.
module tb_spike_rate_encoder;

    localparam int N = 4;
    localparam int W = 8;
    localparam int S = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic          rst;
    logic          pixel_valid;
    logic [W-1:0]  pixel_data;
    logic          pixel_ready;
    logic          start;
    logic          busy;
    logic          done;
    logic          spike_valid;
    logic [N-1:0]  spike_out;

    // Single-lane, single-step instance
    logic          rst1;
    logic          pv1;
    logic [W-1:0]  pd1;
    logic          pr1;
    logic          start1;
    logic          busy1;
    logic          done1;
    logic          sv1;
    logic [0:0]    so1;

    spike_rate_encoder #(
        .NUM_INPUTS(N), .PIXEL_WIDTH(W), .NUM_STEPS(S), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .pixel_ready(pixel_ready), .start(start), .busy(busy), .done(done),
        .spike_valid(spike_valid), .spike_out(spike_out)
    );

    spike_rate_encoder #(
        .NUM_INPUTS(1), .PIXEL_WIDTH(W), .NUM_STEPS(1), .LFSR_SEED(16'hACE1)
    ) dut1 (
        .clk(clk), .rst(rst1), .pixel_valid(pv1), .pixel_data(pd1),
        .pixel_ready(pr1), .start(start1), .busy(busy1), .done(done1),
        .spike_valid(sv1), .spike_out(so1)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] vec;
        logic         last;
    } exp_t;

    exp_t expq[$];
    int   model_pix [N];
    int   exp_cnt   [N];
    int   got_cnt   [N];
    int   saved_cnt [N];
    int   valid_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the LFSR definition.
    function automatic int lfsr_step(input int x);
        if (x % 2 == 1) return (x / 2) ^ 'hB400;
        return x / 2;
    endfunction

    function automatic int seed_of(input int lane);
        int s;
        s = ('hACE1 + lane * 'h1F3) % 65536;
        return (s == 0) ? 1 : s;
    endfunction

    task automatic push_run();
        int   l [N];
        exp_t e;
        for (int i = 0; i < N; i++) begin
            l[i]       = seed_of(i);
            exp_cnt[i] = 0;
            got_cnt[i] = 0;
        end
        valid_cnt = 0;
        for (int t = 0; t < S; t++) begin
            e.vec = '0;
            for (int i = 0; i < N; i++) begin
                if ((l[i] / (1 << (16 - W))) < model_pix[i]) begin
                    e.vec[i] = 1'b1;
                    exp_cnt[i]++;
                end
                l[i] = lfsr_step(l[i]);
            end
            e.last = (t == S - 1);
            expq.push_back(e);
        end
    endtask

    // Monitor: pops one expectation per presented vector.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (spike_valid === 1'b1) begin
            valid_cnt++;
            for (int i = 0; i < N; i++) begin
                if (spike_out[i]) got_cnt[i]++;
            end
            check("queue_has_entry", (expq.size() > 0), 1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("spike_out", spike_out, e.vec);
                check("done_on_last", done, e.last);
            end
        end else begin
            check("idle_spike_out", spike_out, 0);
            check("idle_done", done, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int v, input int gap);
        pixel_valid = 1'b1;
        pixel_data  = W'(v);
        tick();
        pixel_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic run_and_check();
        bit seen;
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("no_valid_at_start_edge", spike_valid, 0);
        check("not_ready_in_run", pixel_ready, 0);
        seen = 0;
        for (int c = 0; c < S + 20 && !seen; c++) begin
            tick();
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        tick();
        check("valid_after_done", spike_valid, 0);
        check("busy_after_done", busy, 0);
        check("ready_after_done", pixel_ready, 1);
        @(negedge clk);
        check("valid_count", valid_cnt, S);
        check("queue_drained", expq.size(), 0);
        for (int i = 0; i < N; i++) begin
            check("bit_count", got_cnt[i], exp_cnt[i]);
        end
        expq.delete();
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; pixel_valid = 1'b0; pixel_data = '0; start = 1'b0;
        rst1 = 1'b1; pv1 = 1'b0; pd1 = '0; start1 = 1'b0;
        for (int i = 0; i < N; i++) model_pix[i] = 0;

        // Reset behaviour
        tick(); tick();
        check("rst_pixel_ready", pixel_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_spike_valid", spike_valid, 0);
        check("rst_spike_out", spike_out, 0);
        rst = 1'b0; rst1 = 1'b0;
        tick();
        check("post_rst_pixel_ready", pixel_ready, 1);
        check("post_rst_busy", busy, 0);

        // Load with gaps; start during LOAD must be ignored
        write_px(0, 2);
        write_px(255, 1);
        start = 1'b1; tick(); start = 1'b0;
        check("start_ignored_in_load", busy, 0);
        write_px(128, 3);
        write_px(64, 0);
        model_pix[0] = 0; model_pix[1] = 255; model_pix[2] = 128; model_pix[3] = 64;
        check("ready_after_load", pixel_ready, 1);
        check("idle_after_load", busy, 0);

        // First run, then a repeat that must match exactly
        run_and_check();
        check("bit0_silent", got_cnt[0], 0);
        for (int i = 0; i < N; i++) saved_cnt[i] = got_cnt[i];
        run_and_check();
        for (int i = 0; i < N; i++) check("repeat_run_count", got_cnt[i], saved_cnt[i]);

        // Write and start together in READY: write wins, idx moves to 1
        pixel_valid = 1'b1; pixel_data = W'(200); start = 1'b1;
        tick();
        pixel_valid = 1'b0; start = 1'b0;
        check("collision_busy", busy, 0);
        check("collision_ready", pixel_ready, 1);
        model_pix[0] = 200;
        write_px(10, 1);
        write_px(90, 0);
        model_pix[1] = 10; model_pix[2] = 90;
        start = 1'b1; tick(); start = 1'b0;
        check("start_ignored_idx3", busy, 0);
        write_px(250, 0);
        model_pix[3] = 250;
        run_and_check();

        // Randomized pixel loads
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                model_pix[i] = $urandom_range(0, 255);
                write_px(model_pix[i], $urandom_range(0, 2));
            end
            run_and_check();
        end

        // Asynchronous reset in the middle of a run
        push_run();
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_valid", spike_valid, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_done", done, 0);
        check("midrun_rst_ready", pixel_ready, 1);
        expq.delete();
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check("start_ignored_after_rst", busy, 0);
        for (int i = 0; i < N; i++) begin
            model_pix[i] = $urandom_range(0, 255);
            write_px(model_pix[i], 0);
        end
        run_and_check();

        // Single-lane, single-step instance
        check("n1_ready", pr1, 1);
        pv1 = 1'b1; pd1 = W'(200);
        tick();
        pv1 = 1'b0;
        check("n1_ready_after_write", pr1, 1);
        check("n1_busy_after_write", busy1, 0);
        for (int rep = 0; rep < 2; rep++) begin
            start1 = 1'b1; tick(); start1 = 1'b0;
            check("n1_busy", busy1, 1);
            check("n1_no_valid_yet", sv1, 0);
            tick();
            check("n1_valid", sv1, 1);
            check("n1_done", done1, 1);
            check("n1_spike", so1, ((seed_of(0) / 256) < 200) ? 1 : 0);
            tick();
            check("n1_valid_end", sv1, 0);
            check("n1_done_end", done1, 0);
            check("n1_busy_end", busy1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Rate-codes a vector of pixel intensities into per-timestep spike trains for the first integrate-and-fire layer. The block sits directly upstream of the IF layer and drives its `spike_in` bus. Pixels are loaded over a valid/ready stream. A `start` pulse then runs a fixed number of timesteps, each emitting one spike vector from LFSR-vs-intensity comparisons.

## Interface
- `NUM_INPUTS`, 4: number of pixels and spike lines; must equal the IF layer's `NUM_INPUTS`.
- `PIXEL_WIDTH`, 8: intensity width, 1..16.
- `NUM_STEPS`, 100: timesteps per run, ≥1.
- `LFSR_SEED`, 16'hACE1: base seed, nonzero.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `pixel_valid`  in  1: pixel write request.
- `pixel_data`  in  PIXEL_WIDTH: intensity, unsigned.
- `pixel_ready`  out  1: write accepted when high with `pixel_valid`.
- `start`  in  1: begin run, one-cycle pulse expected.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse at run end.
- `spike_valid`  out  1: `spike_out` carries a timestep.
- `spike_out`  out  NUM_INPUTS: spike vector; bit i corresponds to pixel i.

## Operation
- States:
  - LOAD: collecting pixels. Reset state.
  - READY: all pixels held.
  - RUN: generating spikes.
- LOAD:
  - Each accepted write stores to `pixel[idx]` and increments `idx`.
  - The write at `idx == NUM_INPUTS-1` sets `idx` to 0 and moves the state to READY.
  - `start` is ignored.
- READY:
  - An accepted write stores `pixel[0]`, sets `idx` to 1 and moves the state to LOAD. If `NUM_INPUTS == 1`, the state stays READY.
  - `start` with no accepted write moves the state to RUN. If both arrive in the same cycle, the write wins and `start` is dropped.
- RUN:
  - `pixel_ready` is 0 and `start` is ignored.
  - Pixels are retained after the run, so `start` may be repeated.
- Randomness:
  - One 16-bit Galois LFSR per input, taps 16'hB400, shifting right.
  - Seed for input i is `LFSR_SEED + i*16'h01F3`. A seed that evaluates to 0 is replaced with 16'h0001.
  - All LFSRs reload their seeds when `start` is accepted, so runs are deterministic and repeatable.
- Spike rule: `spike_out[i] = (lfsr_i[15 -: PIXEL_WIDTH] < pixel[i])`, unsigned compare.
  - Pixel 0 never spikes.
  - Pixel at maximum value spikes with probability (2^W−1)/2^W.
- `spike_out` is forced to 0 whenever `spike_valid` is 0.

## Timing
- Reset values:
  - state LOAD, `idx` 0, all pixels 0, LFSRs at seeds, step counter 0.
  - `pixel_ready` 1, `busy` 0, `done` 0, `spike_valid` 0, `spike_out` 0.
- All outputs are registered. `pixel_ready` is 1 exactly in LOAD and READY.
- Edge E0, `start` accepted:
  - state becomes RUN, step counter 0, LFSRs reseeded, `busy` 1.
- Each RUN edge:
  - `spike_out` takes the compare of the current LFSR values and `spike_valid` is 1.
  - LFSRs advance and the step counter increments.
- Edge with step counter `== NUM_STEPS-1`:
  - Last vector is registered and `done` is 1 for one cycle.
  - State returns to READY and `busy` is 0.
- Next edge: `spike_valid` and `spike_out` return to 0.
- Net result: `spike_valid` is high for exactly NUM_STEPS consecutive cycles starting one cycle after E0.
- Step counter width is `$clog2(NUM_STEPS+1)`. `idx` width is `max(1,$clog2(NUM_INPUTS))`.
- `rst` asserted mid-run: every register returns to its reset value immediately. Pixels are lost and no `done` pulse is produced.

## Structure
- Shared package `snn_pkg`:
  - `enc_state_t` enum {LOAD, READY, RUN}.
  - `LFSR_TAPS = 16'hB400`, `SEED_STRIDE = 16'h01F3`.
  - Function `lfsr16_next`.
- Sub-module `lfsr16`:
  - Ports: `clk`, `rst`, `load`, `seed`, `en`, `q`.
  - One instance per input, generated.
- Top contains the FSM, pixel register file, step counter and comparators.

## Test plan
- Reset: during and after `rst` every output matches its reset value. Asserting `rst` asynchronously mid-RUN clears `spike_valid` before the next edge.
- Load:
  - Stimulus: pixels {0,255,128,64} with idle gaps on `pixel_valid`.
  - Response: READY after the 4th write. `start` pulsed during LOAD is ignored (`busy` stays 0).
- Run with `NUM_STEPS`=100:
  - `spike_valid` is high exactly 100 cycles, starting 1 cycle after the start edge.
  - `done` pulses on the cycle of the 100th vector.
  - Bit 0 is never set.
  - Per-bit spike counts match the golden LFSR model bit-exactly.
- Repeat `start` from READY: the spike train is identical to the first run.
- Simultaneous `start` and `pixel_valid` in READY: pixel 0 is overwritten, state goes to LOAD with `idx` 1, and `busy` stays 0.
- `NUM_INPUTS`=1, `NUM_STEPS`=1: a single write gives READY, and `start` gives exactly one valid cycle coincident with `done`.
